instruction_fetch: RTL and testbench

Instruction fetch and field-decode unit for the multicycle processor. It owns the program counter, fetches instruction words from instruction memory over a request/acknowledge handshake, and presents the decoded `type`/`op` fields and operand fields to the control unit and datapath. It acts on the control unit's `W_IM`, `W_PC` and `S_MXPC` strobes, and `IF_BUSY` lets the control FSM stall while a fetch is outstanding.

---
 rtl/instruction_fetch_if.sv | 24 ++
 rtl/instruction_fetch.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
// One request is outstanding at a time; IM_ACK returns data for exactly one cycle.
interface instruction_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              IM_REQ;
  logic [ADDR_W-1:0] IM_ADDR;
  logic              IM_ACK;
  logic [31:0]       IM_DATA;

  modport master (
    output IM_REQ,
    output IM_ADDR,
    input  IM_ACK,
    input  IM_DATA
  );

  modport slave (
    input  IM_REQ,
    input  IM_ADDR,
    output IM_ACK,
    output IM_DATA
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch and field decode: owns PC, fetches over the IM request/ack channel.
// Optional fetch watchdog enabled by defining IF_TIMEOUT_EN.
module instruction_fetch #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic                CLK,
  input  logic                RST,
  instruction_fetch_if.master imem,
  input  logic                W_IM,
  input  logic                W_PC,
  input  logic                S_MXPC,
  input  logic [ADDR_W-1:0]   BR_TARGET,
  output logic [ADDR_W-1:0]   PC,
  // "type" is a reserved word, so the IR[31:29] field is exported as ins_type
  output logic [2:0]          ins_type,
  output logic [4:0]          op,
  output logic [3:0]          RC,
  output logic [3:0]          RA,
  output logic [3:0]          RB,
  output logic [15:0]         IMM,
  output logic                IR_VALID,
  output logic                IF_BUSY,
  output logic                IM_ERR
);

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       ir;
  logic              dirty;
  logic              stale;
  logic              ir_valid;
  logic              im_req;

  logic              start;
  logic              timeout;
  logic              stay_fetch;

  assign start      = (state == IDLE) && W_IM && dirty;
  assign stay_fetch = start || ((state == FETCH) && !imem.IM_ACK && !timeout);
  assign pc_next    = S_MXPC ? BR_TARGET : pc + ADDR_W'(1);

`ifdef IF_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wd_cnt;
  logic          im_err;

  assign timeout = (state == FETCH) && !imem.IM_ACK && (wd_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt <= '0;
      im_err <= 1'b0;
    end else begin
      if (start) begin
        wd_cnt <= '0;
      end else if ((state == FETCH) && !imem.IM_ACK && !timeout) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
      if (timeout) begin
        im_err <= 1'b1;
      end
    end
  end

  assign IM_ERR = im_err;
`else
  // Watchdog limit has no effect in this build.
  localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;

  assign timeout = 1'b0;
  assign IM_ERR  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      fetch_addr <= '0;
      ir         <= '0;
      dirty      <= 1'b1;
      stale      <= 1'b0;
      ir_valid   <= 1'b0;
      im_req     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            fetch_addr <= pc;
            im_req     <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (imem.IM_ACK) begin
            if (!stale) begin
              ir       <= imem.IM_DATA;
              ir_valid <= 1'b1;
              dirty    <= 1'b0;
            end
            stale  <= 1'b0;
            im_req <= 1'b0;
            state  <= IDLE;
          end else if (timeout) begin
            stale    <= 1'b0;
            ir_valid <= 1'b0;
            im_req   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          im_req <= 1'b0;
        end
      endcase

      // PC write comes last so it overrides a same-cycle load; stale is only
      // marked when the fetch will still be in flight after this edge.
      if (W_PC) begin
        pc       <= pc_next;
        dirty    <= 1'b1;
        ir_valid <= 1'b0;
        if (stay_fetch) begin
          stale <= 1'b1;
        end
      end
    end
  end

  assign imem.IM_REQ  = im_req;
  assign imem.IM_ADDR = fetch_addr;
  assign IF_BUSY      = im_req;
  assign IR_VALID     = ir_valid;
  assign PC           = pc;

  assign ins_type = ir[31:29];
  assign op       = ir[28:24];
  assign RC       = ir[23:20];
  assign RA       = ir[19:16];
  assign RB       = ir[15:12];
  assign IMM      = ir[15:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a wait-state memory model answers requests,
// expected instruction words are queued when a fetch is issued and checked on load.
module tb_instruction_fetch;
  localparam int          ADDR_W      = 16;
  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam int          TIMEOUT_CYC = 15;

  logic        CLK = 1'b0;
  logic        RST;
  logic        W_IM;
  logic        W_PC;
  logic        S_MXPC;
  logic [15:0] BR_TARGET;
  logic [15:0] PC;
  logic [2:0]  ins_type;
  logic [4:0]  op;
  logic [3:0]  RC, RA, RB;
  logic [15:0] IMM;
  logic        IR_VALID;
  logic        IF_BUSY;
  logic        IM_ERR;

  instruction_fetch_if #(.ADDR_W(ADDR_W)) imem ();

  instruction_fetch #(
    .ADDR_W     (ADDR_W),
    .RESET_PC   (RESET_PC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imem     (imem),
    .W_IM     (W_IM),
    .W_PC     (W_PC),
    .S_MXPC   (S_MXPC),
    .BR_TARGET(BR_TARGET),
    .PC       (PC),
    .ins_type (ins_type),
    .op       (op),
    .RC       (RC),
    .RA       (RA),
    .RB       (RB),
    .IMM      (IMM),
    .IR_VALID (IR_VALID),
    .IF_BUSY  (IF_BUSY),
    .IM_ERR   (IM_ERR)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_pc;
  logic [31:0] model_ir;
  logic [31:0] sb_q[$];

  // memory model: automatic responder, or manual ack/data from the tasks
  bit          mem_en   = 1'b1;
  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic        mem_ack  = 1'b0;
  logic [31:0] mem_data = '0;
  logic        man_ack  = 1'b0;
  logic [31:0] man_data = '0;

  assign imem.IM_ACK  = mem_en ? mem_ack  : man_ack;
  assign imem.IM_DATA = mem_en ? mem_data : man_data;

  wire [31:0] ir_view = {ins_type, op, RC, RA, RB, IMM[11:0]};

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 32'h2A3C5001;
    return {a ^ 16'hC0DE, a};
  endfunction

  always @(negedge CLK) begin
    if (mem_en) begin
      if (imem.IM_REQ && !mem_ack) begin
        if (wait_cnt >= mem_wait) begin
          mem_ack  = 1'b1;
          mem_data = mem_word(imem.IM_ADDR);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic run_fetch(input int waits, input string tag);
    logic [31:0] exp;
    mem_wait = waits;
    W_IM = 1'b1;
    sb_q.push_back(mem_word(model_pc));
    step();
    W_IM = 1'b0;
    n_checks++;
    if (imem.IM_REQ !== 1'b1 || imem.IM_ADDR !== model_pc) begin
      n_fail++;
      $display("FAIL %s_req: req=%b addr=%h, required req=1 addr=%h", tag, imem.IM_REQ, imem.IM_ADDR, model_pc);
    end
    for (int i = 0; i < 40 && IR_VALID !== 1'b1; i++) step();
    n_checks++;
    if (IR_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid: IR_VALID=%b, required 1", tag, IR_VALID);
    end
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_queue: scoreboard empty, required one entry", tag);
    end else begin
      exp = sb_q.pop_front();
      model_ir = exp;
      if (ir_view !== exp) begin
        n_fail++;
        $display("FAIL %s_ir: ir=%h, required %h", tag, ir_view, exp);
      end
    end
  endtask

  task automatic write_pc(input logic sel, input logic [15:0] tgt);
    W_PC = 1'b1;
    S_MXPC = sel;
    BR_TARGET = tgt;
    step();
    W_PC = 1'b0;
    model_pc = sel ? tgt : model_pc + 16'd1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    W_IM = 1'b0;
    W_PC = 1'b0;
    S_MXPC = 1'b0;
    BR_TARGET = '0;
    repeat (2) step();
    n_checks++;
    if (PC !== RESET_PC || ir_view !== 32'h0 || IMM !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_pc_ir: pc=%h ir=%h, required pc=%h ir=0", PC, ir_view, RESET_PC);
    end
    n_checks++;
    if ({imem.IM_REQ, IR_VALID, IF_BUSY, IM_ERR} !== 4'b0000 || imem.IM_ADDR !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_flags: req=%b valid=%b busy=%b err=%b addr=%h, required all 0",
               imem.IM_REQ, IR_VALID, IF_BUSY, IM_ERR, imem.IM_ADDR);
    end
    RST = 1'b0;
    model_pc = RESET_PC;
    model_ir = '0;
  endtask

  task automatic test_first_fetch();
    logic [31:0] exp;
    mem_wait = 0;
    W_IM = 1'b1;
    sb_q.push_back(mem_word(model_pc));
    step();
    W_IM = 1'b0;
    n_checks++;
    if (imem.IM_REQ !== 1'b1 || IF_BUSY !== 1'b1 || imem.IM_ADDR !== 16'h0000 || IR_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL first_cycle1: req=%b busy=%b addr=%h valid=%b, required 1 1 0000 0",
               imem.IM_REQ, IF_BUSY, imem.IM_ADDR, IR_VALID);
    end
    step();
    n_checks++;
    if (IR_VALID !== 1'b1 || imem.IM_REQ !== 1'b0) begin
      n_fail++;
      $display("FAIL first_cycle2: valid=%b req=%b, required valid=1 req=0", IR_VALID, imem.IM_REQ);
    end
    n_checks++;
    if ({ins_type, op, RC, RA, RB, IMM} !== {3'b001, 5'b01010, 4'h3, 4'hC, 4'h5, 16'h5001}) begin
      n_fail++;
      $display("FAIL first_fields: type=%b op=%b rc=%h ra=%h rb=%h imm=%h, required 001 01010 3 c 5 5001",
               ins_type, op, RC, RA, RB, IMM);
    end
    exp = sb_q.pop_front();
    model_ir = exp;
    n_checks++;
    if (ir_view !== exp) begin
      n_fail++;
      $display("FAIL first_ir: ir=%h, required %h", ir_view, exp);
    end
  endtask

  task automatic test_held_w_im();
    int          pulses;
    logic        prev;
    logic [15:0] pulse_addr;
    logic [31:0] exp;
    write_pc(1'b1, 16'h0010);
    n_checks++;
    if (PC !== model_pc || IR_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL held_pcwrite: pc=%h valid=%b, required pc=%h valid=0", PC, IR_VALID, model_pc);
    end
    mem_wait = 1;
    W_IM = 1'b1;
    sb_q.push_back(mem_word(model_pc));
    pulses = 0;
    prev = 1'b0;
    pulse_addr = 'x;
    repeat (10) begin
      step();
      if (imem.IM_REQ === 1'b1 && !prev) begin
        pulses++;
        pulse_addr = imem.IM_ADDR;
      end
      prev = imem.IM_REQ;
    end
    W_IM = 1'b0;
    n_checks++;
    if (pulses != 1 || pulse_addr !== model_pc) begin
      n_fail++;
      $display("FAIL held_pulses: pulses=%0d addr=%h, required 1 pulse at %h", pulses, pulse_addr, model_pc);
    end
    n_checks++;
    exp = sb_q.pop_front();
    model_ir = exp;
    if (IR_VALID !== 1'b1 || ir_view !== exp) begin
      n_fail++;
      $display("FAIL held_ir: valid=%b ir=%h, required valid=1 ir=%h", IR_VALID, ir_view, exp);
    end
  endtask

  task automatic test_sequential_branch();
    write_pc(1'b1, 16'hFFFF);
    run_fetch(0, "top_fetch");
    write_pc(1'b0, 16'h0000);
    n_checks++;
    if (PC !== 16'h0000 || model_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL seq_wrap: pc=%h, required 0000", PC);
    end
    n_checks++;
    if (IR_VALID !== 1'b0 || ir_view !== model_ir) begin
      n_fail++;
      $display("FAIL seq_invalidate: valid=%b ir=%h, required valid=0 ir=%h", IR_VALID, ir_view, model_ir);
    end
    write_pc(1'b1, 16'h0040);
    n_checks++;
    if (PC !== 16'h0040) begin
      n_fail++;
      $display("FAIL branch_pc: pc=%h, required 0040", PC);
    end
    run_fetch(2, "branch_fetch");
  endtask

  task automatic test_stale();
    logic [15:0] old_pc;
    write_pc(1'b0, 16'h0000);
    old_pc = model_pc;
    mem_wait = 3;
    W_IM = 1'b1;
    step();
    W_IM = 1'b0;
    n_checks++;
    if (imem.IM_REQ !== 1'b1 || imem.IM_ADDR !== old_pc) begin
      n_fail++;
      $display("FAIL stale_req: req=%b addr=%h, required req=1 addr=%h", imem.IM_REQ, imem.IM_ADDR, old_pc);
    end
    step();
    write_pc(1'b0, 16'h0000);
    for (int i = 0; i < 20 && imem.IM_REQ === 1'b1; i++) step();
    n_checks++;
    if (imem.IM_REQ !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_done: req=%b, required 0 within bound", imem.IM_REQ);
    end
    n_checks++;
    if (IR_VALID !== 1'b0 || ir_view !== model_ir || PC !== model_pc) begin
      n_fail++;
      $display("FAIL stale_discard: valid=%b ir=%h pc=%h, required valid=0 ir=%h pc=%h",
               IR_VALID, ir_view, PC, model_ir, model_pc);
    end
    run_fetch(0, "after_stale");
  endtask

  task automatic test_reset_mid_fetch();
    write_pc(1'b1, 16'h1234);
    mem_en = 1'b0;
    man_ack = 1'b0;
    W_IM = 1'b1;
    step();
    W_IM = 1'b0;
    n_checks++;
    if (imem.IM_REQ !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_req: req=%b, required 1", imem.IM_REQ);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    model_pc = RESET_PC;
    model_ir = '0;
    n_checks++;
    if (imem.IM_REQ !== 1'b0 || PC !== RESET_PC || IR_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: req=%b pc=%h valid=%b, required 0 %h 0", imem.IM_REQ, PC, IR_VALID, RESET_PC);
    end
    man_ack = 1'b1;
    man_data = 32'hDEADBEEF;
    step();
    man_ack = 1'b0;
    step();
    n_checks++;
    if (IR_VALID !== 1'b0 || ir_view !== 32'h0 || imem.IM_REQ !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack: valid=%b ir=%h req=%b, required 0 00000000 0", IR_VALID, ir_view, imem.IM_REQ);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] old_pc;
    // W_PC coinciding with IM_ACK
    old_pc = model_pc;
    W_IM = 1'b1;
    step();
    W_IM = 1'b0;
    man_ack = 1'b1;
    man_data = mem_word(old_pc);
    W_PC = 1'b1;
    S_MXPC = 1'b0;
    step();
    man_ack = 1'b0;
    W_PC = 1'b0;
    model_pc = model_pc + 16'd1;
    model_ir = mem_word(old_pc);
    n_checks++;
    if (ir_view !== model_ir || IR_VALID !== 1'b0 || PC !== model_pc || imem.IM_REQ !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_and_pc: ir=%h valid=%b pc=%h req=%b, required ir=%h valid=0 pc=%h req=0",
               ir_view, IR_VALID, PC, imem.IM_REQ, model_ir, model_pc);
    end
    mem_en = 1'b1;
    run_fetch(0, "after_ack_pc");
    // W_PC coinciding with the fetch start
    write_pc(1'b1, 16'h0200);
    old_pc = model_pc;
    mem_wait = 1;
    W_IM = 1'b1;
    W_PC = 1'b1;
    S_MXPC = 1'b1;
    BR_TARGET = 16'h0300;
    step();
    W_IM = 1'b0;
    W_PC = 1'b0;
    model_pc = 16'h0300;
    n_checks++;
    if (imem.IM_ADDR !== old_pc || imem.IM_REQ !== 1'b1) begin
      n_fail++;
      $display("FAIL start_and_pc_addr: addr=%h req=%b, required addr=%h req=1", imem.IM_ADDR, imem.IM_REQ, old_pc);
    end
    for (int i = 0; i < 20 && imem.IM_REQ === 1'b1; i++) step();
    n_checks++;
    if (IR_VALID !== 1'b0 || ir_view !== model_ir || PC !== model_pc || imem.IM_REQ !== 1'b0) begin
      n_fail++;
      $display("FAIL start_and_pc_discard: valid=%b ir=%h pc=%h req=%b, required 0 %h %h 0",
               IR_VALID, ir_view, PC, imem.IM_REQ, model_ir, model_pc);
    end
    run_fetch(1, "after_start_pc");
  endtask

`ifdef IF_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles;
    step();
    mem_en = 1'b0;
    man_ack = 1'b0;
    write_pc(1'b1, 16'h0777);
    W_IM = 1'b1;
    step();
    W_IM = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (imem.IM_REQ !== 1'b1) break;
      req_cycles++;
      step();
    end
    n_checks++;
    if (req_cycles != TIMEOUT_CYC || IM_ERR !== 1'b1 || imem.IM_REQ !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fire: req_cycles=%0d err=%b req=%b, required %0d 1 0",
               req_cycles, IM_ERR, imem.IM_REQ, TIMEOUT_CYC);
    end
    repeat (5) step();
    n_checks++;
    if (IM_ERR !== 1'b1 || IR_VALID !== 1'b0 || PC !== model_pc) begin
      n_fail++;
      $display("FAIL timeout_sticky: err=%b valid=%b pc=%h, required 1 0 %h", IM_ERR, IR_VALID, PC, model_pc);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_checks++;
    if (IM_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: err=%b, required 0", IM_ERR);
    end
    mem_en = 1'b1;
  endtask
`else
  task automatic test_no_timeout();
    step();
    mem_en = 1'b0;
    man_ack = 1'b0;
    write_pc(1'b1, 16'h0777);
    W_IM = 1'b1;
    step();
    W_IM = 1'b0;
    repeat (20) step();
    n_checks++;
    if (imem.IM_REQ !== 1'b1 || IM_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_forever: req=%b err=%b, required req=1 err=0", imem.IM_REQ, IM_ERR);
    end
    man_ack = 1'b1;
    man_data = mem_word(model_pc);
    step();
    man_ack = 1'b0;
    step();
    n_checks++;
    if (IR_VALID !== 1'b1 || ir_view !== mem_word(model_pc)) begin
      n_fail++;
      $display("FAIL late_load: valid=%b ir=%h, required valid=1 ir=%h", IR_VALID, ir_view, mem_word(model_pc));
    end
    mem_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_held_w_im();
    test_sequential_branch();
    test_stale();
    test_reset_mid_fetch();
    test_back_to_back();
`ifdef IF_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running at %0t, required completion", $time);
    $fatal(1, "time limit");
  end

endmodule
